// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, enums and the control word carried down the pipeline.
package pipe_ctrl_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_JAL  = 2'b10,
    BR_JALR = 2'b11
  } branch_e;

  // Control bits that travel with the instruction; all-zero is a bubble.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;  // 00 ALU, 01 memory, 10 PC+4, 11 immediate
    logic       mem_write;
    branch_e    branch;
    logic       alu_src;
    logic       reg_src;
    logic [2:0] funct3;
  } ctrl_word_t;

endpackage

// File: rtl/hazard_unit.sv
// Combinational stall / flush / forward generation.
// PIPE_FORWARDING_EN: defined -> M/W forwarding; undefined -> RAW stalls, forwards tied to 00.
module hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs1_d,
  input  logic [REG_ADDR_W-1:0] i_rs2_d,
  input  logic [REG_ADDR_W-1:0] i_rs1_e,
  input  logic [REG_ADDR_W-1:0] i_rs2_e,
  input  logic [REG_ADDR_W-1:0] i_rd_e,
  input  logic [REG_ADDR_W-1:0] i_rd_m,
  input  logic [REG_ADDR_W-1:0] i_rd_w,
  input  logic                  i_reg_write_e,
  input  logic                  i_reg_write_m,
  input  logic                  i_reg_write_w,
  input  logic [1:0]            i_result_src_e,
  input  logic [1:0]            i_pc_src_e,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic [1:0]            o_forward_a_e,
  output logic [1:0]            o_forward_b_e
);

  logic w_lw_stall;
  logic w_raw_stall;
  logic w_stall;
  logic w_taken;

  assign w_lw_stall = (i_result_src_e == 2'b01) && (i_rd_e != '0) &&
                      ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

`ifdef PIPE_FORWARDING_EN
  // Forward select per operand; M is newer than W so it wins.
  always_comb begin
    o_forward_a_e = 2'b00;
    o_forward_b_e = 2'b00;
    if (i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs1_e)) begin
      o_forward_a_e = 2'b10;
    end else if (i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs1_e)) begin
      o_forward_a_e = 2'b01;
    end
    if (i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs2_e)) begin
      o_forward_b_e = 2'b10;
    end else if (i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs2_e)) begin
      o_forward_b_e = 2'b01;
    end
  end

  assign w_raw_stall = 1'b0;
`else
  logic w_unused_fwd;

  assign o_forward_a_e = 2'b00;
  assign o_forward_b_e = 2'b00;
  assign w_unused_fwd  = ^{i_rs1_e, i_rs2_e, i_rd_w, i_reg_write_w};

  // Without forwarding, hold D until the producer has reached W (write-first RF).
  assign w_raw_stall =
      ((i_rs1_d != '0) && ((i_reg_write_e && (i_rd_e == i_rs1_d)) ||
                           (i_reg_write_m && (i_rd_m == i_rs1_d)))) ||
      ((i_rs2_d != '0) && ((i_reg_write_e && (i_rd_e == i_rs2_d)) ||
                           (i_reg_write_m && (i_rd_m == i_rs2_d))));
`endif

  assign w_taken = (i_pc_src_e != PC_PLUS4);
  assign w_stall = w_lw_stall | w_raw_stall;

  // A redirect discards the stalled instruction anyway, so flush beats stall.
  assign o_stall_f = w_stall & ~w_taken;
  assign o_stall_d = w_stall & ~w_taken;
  assign o_flush_d = w_taken;
  assign o_flush_e = w_stall | w_taken;

endmodule

// File: rtl/pipelined_control_unit.sv
// Five-stage RV32I control unit: D decode, D/E, E/M, M/W control registers, E branch resolve.
// PIPE_FORWARDING_EN selects forwarding (defined) or RAW stalling (undefined) in hazard_unit.
module pipelined_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUCTRL_W  = 4,
  parameter int unsigned IMMSRC_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opD,
  input  logic [2:0]            funct3D,
  input  logic                  funct7_5D,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic                  zeroE,
  input  logic                  ltE,
  input  logic                  ltuE,
  output logic [IMMSRC_W-1:0]   ImmSrcD,
  output logic [ALUCTRL_W-1:0]  ALUControlE,
  output logic                  ALUSrcE,
  output logic                  RegSrcE,
  output logic [1:0]            PCSrcE,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcW,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] rdW,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
);

  ctrl_word_t            w_ctrl_d;
  logic [1:0]            w_alu_op;
  logic [2:0]            w_imm_src;
  logic [3:0]            w_alu_ctrl;
  logic                  w_cond_e;
  pcsrc_e                w_pc_src_e;

  ctrl_word_t            r_ctrl_e;
  logic [ALUCTRL_W-1:0]  r_alu_ctrl_e;
  logic [REG_ADDR_W-1:0] r_rd_e, r_rs1_e, r_rs2_e;
  logic                  r_reg_write_m, r_mem_write_m;
  logic [1:0]            r_result_src_m;
  logic [REG_ADDR_W-1:0] r_rd_m;
  logic                  r_reg_write_w;
  logic [1:0]            r_result_src_w;
  logic [REG_ADDR_W-1:0] r_rd_w;

  // Main decoder: opcode to control word, ALU op class and immediate format.
  always_comb begin
    w_ctrl_d        = '0;
    w_ctrl_d.funct3 = funct3D;
    w_alu_op        = 2'b00;
    w_imm_src       = 3'b000;
    case (opD)
      LOAD:   begin w_ctrl_d.reg_write = 1'b1; w_ctrl_d.result_src = 2'b01;
                    w_ctrl_d.alu_src = 1'b1; end
      STORE:  begin w_ctrl_d.mem_write = 1'b1; w_ctrl_d.alu_src = 1'b1; w_imm_src = 3'b001; end
      OP:     begin w_ctrl_d.reg_write = 1'b1; w_alu_op = 2'b10; end
      OP_IMM: begin w_ctrl_d.reg_write = 1'b1; w_ctrl_d.alu_src = 1'b1; w_alu_op = 2'b10; end
      BRANCH: begin w_ctrl_d.branch = BR_COND; w_alu_op = 2'b01; w_imm_src = 3'b010; end
      JAL:    begin w_ctrl_d.reg_write = 1'b1; w_ctrl_d.result_src = 2'b10;
                    w_ctrl_d.branch = BR_JAL; w_imm_src = 3'b011; end
      JALR:   begin w_ctrl_d.reg_write = 1'b1; w_ctrl_d.result_src = 2'b10;
                    w_ctrl_d.alu_src = 1'b1; w_ctrl_d.branch = BR_JALR; end
      LUI:    begin w_ctrl_d.reg_write = 1'b1; w_ctrl_d.result_src = 2'b11; w_imm_src = 3'b100; end
      AUIPC:  begin w_ctrl_d.reg_write = 1'b1; w_ctrl_d.alu_src = 1'b1;
                    w_ctrl_d.reg_src = 1'b1; w_imm_src = 3'b100; end
      default: ;
    endcase
  end

  // ALU decoder: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
  always_comb begin
    w_alu_ctrl = 4'd0;
    case (w_alu_op)
      2'b01: w_alu_ctrl = 4'd1;
      2'b10: begin
        case (funct3D)
          3'b000:  w_alu_ctrl = (opD[5] && funct7_5D) ? 4'd1 : 4'd0;
          3'b001:  w_alu_ctrl = 4'd7;
          3'b010:  w_alu_ctrl = 4'd5;
          3'b011:  w_alu_ctrl = 4'd6;
          3'b100:  w_alu_ctrl = 4'd4;
          3'b101:  w_alu_ctrl = funct7_5D ? 4'd9 : 4'd8;
          3'b110:  w_alu_ctrl = 4'd3;
          default: w_alu_ctrl = 4'd2;
        endcase
      end
      default: ;
    endcase
  end

  assign ImmSrcD = IMMSRC_W'(w_imm_src);

  // D->E register; FlushE inserts a bubble including cleared rs/rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_e     <= '0;
      r_alu_ctrl_e <= '0;
      r_rd_e       <= '0;
      r_rs1_e      <= '0;
      r_rs2_e      <= '0;
    end else if (FlushE) begin
      r_ctrl_e     <= '0;
      r_alu_ctrl_e <= '0;
      r_rd_e       <= '0;
      r_rs1_e      <= '0;
      r_rs2_e      <= '0;
    end else begin
      r_ctrl_e     <= w_ctrl_d;
      r_alu_ctrl_e <= ALUCTRL_W'(w_alu_ctrl);
      r_rd_e       <= rdD;
      r_rs1_e      <= rs1D;
      r_rs2_e      <= rs2D;
    end
  end

  // E->M and M->W registers carry only what later stages consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= 2'b00;
      r_rd_m         <= '0;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= 2'b00;
      r_rd_w         <= '0;
    end else begin
      r_reg_write_m  <= r_ctrl_e.reg_write;
      r_mem_write_m  <= r_ctrl_e.mem_write;
      r_result_src_m <= r_ctrl_e.result_src;
      r_rd_m         <= r_rd_e;
      r_reg_write_w  <= r_reg_write_m;
      r_result_src_w <= r_result_src_m;
      r_rd_w         <= r_rd_m;
    end
  end

  // Branch condition selected by funct3; reserved encodings never take.
  always_comb begin
    case (r_ctrl_e.funct3)
      3'b000:  w_cond_e = zeroE;
      3'b001:  w_cond_e = ~zeroE;
      3'b100:  w_cond_e = ltE;
      3'b101:  w_cond_e = ~ltE;
      3'b110:  w_cond_e = ltuE;
      3'b111:  w_cond_e = ~ltuE;
      default: w_cond_e = 1'b0;
    endcase
  end

  // Next-PC select resolved in E.
  always_comb begin
    w_pc_src_e = PC_PLUS4;
    case (r_ctrl_e.branch)
      BR_COND: if (w_cond_e) w_pc_src_e = PC_TARGET;
      BR_JAL:  w_pc_src_e = PC_TARGET;
      BR_JALR: w_pc_src_e = PC_ALU;
      default: ;
    endcase
  end

  assign ALUControlE = r_alu_ctrl_e;
  assign ALUSrcE     = r_ctrl_e.alu_src;
  assign RegSrcE     = r_ctrl_e.reg_src;
  assign PCSrcE      = w_pc_src_e;
  assign MemWriteM   = r_mem_write_m;
  assign ResultSrcW  = r_result_src_w;
  assign RegWriteW   = r_reg_write_w;
  assign rdW         = r_rd_w;

  hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_unit (
    .i_rs1_d       (rs1D),
    .i_rs2_d       (rs2D),
    .i_rs1_e       (r_rs1_e),
    .i_rs2_e       (r_rs2_e),
    .i_rd_e        (r_rd_e),
    .i_rd_m        (r_rd_m),
    .i_rd_w        (r_rd_w),
    .i_reg_write_e (r_ctrl_e.reg_write),
    .i_reg_write_m (r_reg_write_m),
    .i_reg_write_w (r_reg_write_w),
    .i_result_src_e(r_ctrl_e.result_src),
    .i_pc_src_e    (w_pc_src_e),
    .o_stall_f     (StallF),
    .o_stall_d     (StallD),
    .o_flush_d     (FlushD),
    .o_flush_e     (FlushE),
    .o_forward_a_e (ForwardAE),
    .o_forward_b_e (ForwardBE)
  );

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Five-stage (F/D/E/M/W) successor to the single-cycle control unit.
- Decodes the RV32I instruction in D and carries the control word through the D→E, E→M and M→W pipeline registers.
- Resolves branches and jumps in E.
- Generates stall, flush and forwarding selects for the datapath, which keeps only data registers.

Parameters:
- REG_ADDR_W, 5, register-index width
- ALUCTRL_W, 4, ALUControl width
- IMMSRC_W, 3, ImmSrc width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opD  in  7  opcode of the instruction in D
- funct3D  in  3  funct3 of the instruction in D
- funct7_5D  in  1  instr[30] in D
- rs1D, rs2D, rdD  in  REG_ADDR_W each  register indices in D
- zeroE  in  1  ALU result == 0
- ltE  in  1  signed less-than from the E-stage ALU
- ltuE  in  1  unsigned less-than from the E-stage ALU
- ImmSrcD  out  IMMSRC_W  immediate select (combinational, D)
- ALUControlE  out  ALUCTRL_W  ALU operation in E
- ALUSrcE  out  1  ALU B-operand select in E
- RegSrcE  out  1  ALU A-operand select in E
- PCSrcE  out  2  PC select: 00 PC+4, 01 PCE+imm, 10 ALU target (jalr)
- MemWriteM  out  1  data-memory write strobe
- ResultSrcW  out  2  writeback mux select
- RegWriteW  out  1  register-file write enable
- rdW  out  REG_ADDR_W  writeback register index
- StallF, StallD  out  1 each  hold PC / hold the IF/ID register
- FlushD, FlushE  out  1 each  bubble the IF/ID / ID/EX register
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 W result, 10 M ALU result

Behaviour:
- Decode: the D-stage decode reuses mainDecoder and aluDecoder logic unchanged. Branch encoding:
  - 00 none
  - 01 conditional branch
  - 10 jal
  - 11 jalr
- Pipeline registers: D→E, E→M and M→W update on the rising edge of clk. Asynchronous clear when rst_n=0.
- Reset and flush value: all-zero control word. This is a bubble: RegWrite=0, MemWrite=0, Branch=00, rd=0.
- Outputs at reset: every registered output is 0. PCSrcE=00. Stall/Flush/Forward outputs are 0.
- E-stage branch condition, indexed by funct3E:
  - 000 zeroE (beq)
  - 001 !zeroE (bne)
  - 100 ltE (blt)
  - 101 !ltE (bge)
  - 110 ltuE (bltu)
  - 111 !ltuE (bgeu)
  - any other funct3 → not taken
- PCSrcE:
  - 01 when (Branch==01 and condition true) or Branch==10
  - 10 when Branch==11
  - 00 otherwise
- Taken branch or jump (PCSrcE≠00): FlushD=1 and FlushE=1 in the same cycle. Penalty is 2 cycles.
- Load-use hazard:
  - Condition: ResultSrcE==01, rdE≠0, and rdE∈{rs1D, rs2D}.
  - Response: StallF=StallD=1 and FlushE=1 for exactly one cycle.
- Priority: a taken branch in E and a load-use hazard are mutually exclusive because E holds one instruction. The RTL still gives flush priority: when PCSrcE≠00, StallF and StallD are forced to 0.
- Forwarding, for rs1E and independently for rs2E:
  - 10 if RegWriteM and rdM≠0 and rdM==rsE.
  - else 01 if RegWriteW and rdW≠0 and rdW==rsE.
  - else 00.
  - M has priority over W.
- rs1E and rs2E are carried in the D→E register. FlushE clears them to 0.
- Register x0 never triggers a hazard or a forward.
- The register file is write-first, so no W→D hazard exists.
- Reset mid-operation: all in-flight instructions are discarded immediately. Outputs go to their reset values without waiting for a clock edge.

Optional Feature:
- Macro: PIPE_FORWARDING_EN.
- Defined: forwarding as specified above.
- Undefined:
  - ForwardAE and ForwardBE are tied to 00.
  - An extra RAW stall is asserted (StallF=StallD=FlushE=1) when rsD∈{rdE, rdM}, the matching stage has RegWrite=1, and rs≠0.
  - The stall repeats until the producer reaches W, i.e. at most 2 cycles.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode localparams (LOAD, STORE, OP, OP_IMM, BRANCH, JAL, JALR, LUI, AUIPC)
  - the pcsrc_e enum {PC_PLUS4, PC_TARGET, PC_ALU}
  - the branch_e enum
  - the packed ctrl_word_t struct carried between stages
- One sub-module, hazard_unit, is purely combinational. It produces the Stall, Flush and Forward outputs from rs/rd/RegWrite/ResultSrc/PCSrcE.

Test Plan:
1. Reset release → first cycle has all outputs 0. After `addi x1,x0,5` enters D, RegWriteW=1 and rdW=1 appear exactly 3 cycles after the D cycle.
2. `add x3,x1,x2` directly after `addi x1` → ForwardAE=10 in E. With one unrelated instruction between them → ForwardAE=01. With PIPE_FORWARDING_EN undefined → 2 stall cycles and Forward=00.
3. `lw x5,0(x0)` then `add x6,x5,x5` → one cycle with StallF=StallD=FlushE=1, then ForwardAE=ForwardBE=01.
4. `bne` with zeroE=0 → PCSrcE=01, FlushD=FlushE=1 for one cycle. Same instruction with zeroE=1 → PCSrcE=00, no flush.
5. `blt`/`bgeu` with ltE=1, ltuE=1 → blt taken (PCSrcE=01), bgeu not taken (00). `jalr` → PCSrcE=10 with flushes.
6. rst_n asserted while a `sw` is in M → MemWriteM falls to 0 asynchronously, before the next clk edge.
